// File: rtl/riscv_pkg.sv
// Shared definitions for the EX-stage branch resolution slice.
// Contents:
//   XLEN        - default datapath width
//   F3_*        - B-type funct3 condition encodings
//   br_state_t  - branch-resolve control state (RUN / SQUASH)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } br_state_t;

endpackage

// File: rtl/compare_32bit.sv
// Unsigned magnitude comparator.
// Ports:
//   a, b  - operands (unsigned)
//   eq    - a == b
//   lt    - a < b (unsigned)
module compare_32bit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/compare_32bit_s.sv
// Signed magnitude comparator.
// Ports:
//   a, b  - operands (two's complement)
//   eq    - a == b
//   lt    - a < b (signed)
module compare_32bit_s #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = (a == b);
  assign lt = ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve.sv
// Branch / jump resolution stage (EX). Decides taken / not-taken for
// B-type, JAL and JALR against a static not-taken prediction, registers
// the result, emits a one-cycle fetch redirect and drops the next
// KILL_SLOTS wrong-path instructions that arrive after a taken accept.
// Ports:
//   i_clk, i_rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready      - upstream handshake
//   is_branch/is_jal/is_jalr - instruction class
//   funct3, pc, imm, rs1, rs2- decoded fields and operands
//   out_valid / out_ready    - downstream handshake
//   taken, link_data         - resolution result, pc+4
//   redirect_valid/_pc       - one-cycle fetch redirect and target
//   misalign, illegal        - taken target bit1 set, reserved funct3
//   flush_i                  - external trap flush (highest priority)
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int W          = XLEN,
  parameter int KILL_SLOTS = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_branch,
  input  logic         is_jal,
  input  logic         is_jalr,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [W-1:0] link_data,
  output logic         redirect_valid,
  output logic [W-1:0] redirect_pc,
  output logic         misalign,
  output logic         illegal,
  input  logic         flush_i
);

  localparam int CW = $clog2(KILL_SLOTS + 1);
  localparam logic [CW-1:0] KILL_INIT = CW'(KILL_SLOTS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  br_state_t     state_r;
  br_state_t     state_nx;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx;

  logic          eq_s;
  logic          lt_s;
  logic          eq_u;
  logic          lt_u;

  logic          cond_s;
  logic          f3_bad_s;
  logic          taken_s;
  logic          illegal_s;
  logic [W-1:0]  jalr_sum_s;
  logic [W-1:0]  target_s;
  logic [W-1:0]  link_s;
  logic          hs_s;
  logic          load_s;

  compare_32bit_s #(.W(W)) u_cmp_s (
    .a  (rs1),
    .b  (rs2),
    .eq (eq_s),
    .lt (lt_s)
  );

  compare_32bit #(.W(W)) u_cmp_u (
    .a  (rs1),
    .b  (rs2),
    .eq (eq_u),
    .lt (lt_u)
  );

  // Branch condition decode from funct3.
  always_comb begin
    cond_s   = 1'b0;
    f3_bad_s = 1'b0;
    case (funct3)
      F3_BEQ:  cond_s = eq_s;
      F3_BNE:  cond_s = ~eq_u;
      F3_BLT:  cond_s = lt_s;
      F3_BGE:  cond_s = ~lt_s;
      F3_BLTU: cond_s = lt_u;
      F3_BGEU: cond_s = ~lt_u;
      default: f3_bad_s = 1'b1;
    endcase
  end

  assign jalr_sum_s = rs1 + imm;
  assign link_s     = pc + W'(4);

  // Resolve taken/target per instruction class; JALR wins if several flags are set.
  always_comb begin
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    target_s  = pc + imm;
    if (is_jalr) begin
      taken_s  = 1'b1;
      target_s = {jalr_sum_s[W-1:1], 1'b0};
    end else if (is_jal) begin
      taken_s  = 1'b1;
    end else if (is_branch) begin
      taken_s   = cond_s;
      illegal_s = f3_bad_s;
    end else begin
      taken_s   = 1'b0;
    end
  end

  // Handshake and next-state logic; SQUASH always accepts so wrong-path work drains.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    load_s   = 1'b0;
    if (state_r == SQUASH) begin
      in_ready = 1'b1;
    end else begin
      in_ready = ~out_valid | out_ready;
    end
    hs_s = in_valid & in_ready & ~flush_i;
    if (flush_i) begin
      state_nx = RUN;
      cnt_nx   = CNT_ZERO;
    end else begin
      case (state_r)
        RUN: begin
          if (hs_s) begin
            load_s = 1'b1;
            if (taken_s) begin
              state_nx = SQUASH;
              cnt_nx   = KILL_INIT;
            end else begin
              state_nx = RUN;
            end
          end else begin
            state_nx = RUN;
          end
        end
        SQUASH: begin
          if (hs_s) begin
            if (cnt_r <= CNT_ONE) begin
              state_nx = RUN;
              cnt_nx   = CNT_ZERO;
            end else begin
              cnt_nx   = cnt_r - CNT_ONE;
            end
          end else begin
            state_nx = SQUASH;
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = CNT_ZERO;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Registered result and redirect; fields only change on a load so they hold while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid      <= 1'b0;
      taken          <= 1'b0;
      link_data      <= {W{1'b0}};
      redirect_valid <= 1'b0;
      redirect_pc    <= {W{1'b0}};
      misalign       <= 1'b0;
      illegal        <= 1'b0;
    end else if (flush_i) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= load_s & taken_s;
      if (load_s) begin
        out_valid   <= 1'b1;
        taken       <= taken_s;
        link_data   <= link_s;
        redirect_pc <= target_s;
        misalign    <= taken_s & target_s[1];
        illegal     <= illegal_s;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
      end else begin
        out_valid   <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a driver issues directed and random
// instructions and pushes the expected result computed from the ISA rules;
// a separate monitor compares every presented output against the queue.
module tb_branch_resolve;
  import riscv_pkg::*;

  localparam int W  = 32;
  localparam int KS = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          is_branch = 1'b0;
  logic          is_jal = 1'b0;
  logic          is_jalr = 1'b0;
  logic [2:0]    funct3 = 3'd0;
  logic [W-1:0]  pc = '0;
  logic [W-1:0]  imm = '0;
  logic [W-1:0]  rs1 = '0;
  logic [W-1:0]  rs2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          taken;
  logic [W-1:0]  link_data;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          misalign;
  logic          illegal;
  logic          flush_i = 1'b0;

  always #5 i_clk = ~i_clk;

  branch_resolve #(.W(W), .KILL_SLOTS(KS)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .is_branch      (is_branch),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .funct3         (funct3),
    .pc             (pc),
    .imm            (imm),
    .rs1            (rs1),
    .rs2            (rs2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .taken          (taken),
    .link_data      (link_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign),
    .illegal        (illegal),
    .flush_i        (flush_i)
  );

  typedef struct {
    logic        taken;
    logic [31:0] link;
    logic [31:0] target;
    logic        misalign;
    logic        illegal;
    int          cyc;
    bit          seen;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   kill_left = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = plain instruction, 1 = B-type, 2 = JAL, 3 = JALR
  function automatic exp_t model(input int kind, input logic [2:0] f3,
                                 input logic [31:0] p, input logic [31:0] im,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.link     = p + 32'd4;
    e.target   = p + im;
    e.taken    = 1'b0;
    e.illegal  = 1'b0;
    e.cyc      = 0;
    e.seen     = 1'b0;
    if (kind == 3) begin
      e.target = (a + im) & 32'hFFFF_FFFE;
      e.taken  = 1'b1;
    end else if (kind == 2) begin
      e.taken  = 1'b1;
    end else if (kind == 1) begin
      case (f3)
        3'd0:    e.taken = (a == b);
        3'd1:    e.taken = (a != b);
        3'd4:    e.taken = ($signed(a) <  $signed(b));
        3'd5:    e.taken = ($signed(a) >= $signed(b));
        3'd6:    e.taken = (a <  b);
        3'd7:    e.taken = (a >= b);
        default: e.illegal = 1'b1;
      endcase
    end
    e.misalign = e.taken && e.target[1];
    return e;
  endfunction

  task automatic issue(input logic iv, input int kind, input logic [2:0] f3,
                       input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
    logic exp_ir;
    exp_t e;
    @(posedge i_clk);
    #2;
    in_valid  = iv;
    is_branch = (kind == 1);
    is_jal    = (kind == 2);
    is_jalr   = (kind == 3);
    funct3    = f3;
    pc        = p;
    imm       = im;
    rs1       = a;
    rs2       = b;
    out_ready = ordy;
    flush_i   = fl;
    #1;
    exp_ir = (kill_left > 0) || (q.size() == 0) || ordy;
    check("in_ready", in_ready, exp_ir);
    if (fl) begin
      kill_left = 0;
    end else if (iv && exp_ir) begin
      if (kill_left > 0) begin
        kill_left--;
      end else begin
        e = model(kind, f3, p, im, a, b);
        e.cyc = cyc;
        q.push_back(e);
        if (e.taken) kill_left = KS;
      end
    end
  endtask

  task automatic filler(input logic ordy);
    issue(1'b1, 0, 3'd0, $urandom, $urandom, $urandom, $urandom, ordy, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    issue(1'b0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  task automatic reset_and_check();
    @(posedge i_clk);
    #2;
    i_rst_n   = 1'b0;
    in_valid  = 1'b0;
    flush_i   = 1'b0;
    kill_left = 0;
    @(posedge i_clk);
    #1;
    check("rst out_valid",      out_valid,      32'd0);
    check("rst taken",          taken,          32'd0);
    check("rst redirect_valid", redirect_valid, 32'd0);
    check("rst redirect_pc",    redirect_pc,    32'd0);
    check("rst link_data",      link_data,      32'd0);
    check("rst misalign",       misalign,       32'd0);
    check("rst illegal",        illegal,        32'd0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  // Monitor: compares the presented output with the scoreboard head.
  initial begin
    logic exp_v;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        q.delete();
        continue;
      end
      exp_v = (q.size() > 0) && (q[0].cyc < cyc);
      check("out_valid", out_valid, exp_v);
      if (exp_v && out_valid) begin
        check("taken",     taken,     q[0].taken);
        check("link_data", link_data, q[0].link);
        check("misalign",  misalign,  q[0].misalign);
        check("illegal",   illegal,   q[0].illegal);
        if (q[0].taken) check("redirect_pc", redirect_pc, q[0].target);
        check("redirect_valid", redirect_valid, q[0].taken && !q[0].seen);
        q[0].seen = 1'b1;
      end else begin
        check("redirect_valid idle", redirect_valid, 32'd0);
      end
      if (flush_i) q.delete();
      else if (exp_v && out_ready) void'(q.pop_front());
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          kind;
    reset_and_check();

    // BEQ taken: two wrong-path inputs dropped, third one appears.
    issue(1'b1, 1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 1'b0);
    filler(1'b1);
    filler(1'b1);
    filler(1'b1);
    idle(1'b1);

    // Signed vs unsigned less-than on the same operands.
    issue(1'b1, 1, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    filler(1'b1);
    filler(1'b1);
    issue(1'b1, 1, 3'd6, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    filler(1'b1);

    // JALR with misaligned target.
    issue(1'b1, 3, 3'd0, 32'h400, 32'h0, 32'h1003, 32'd0, 1'b1, 1'b0);
    filler(1'b1);
    filler(1'b1);
    idle(1'b1);

    // Taken result held by out_ready low for 3 cycles while inputs keep coming.
    issue(1'b1, 1, 3'd1, 32'h500, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0);
    filler(1'b0);
    filler(1'b0);
    filler(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush on the last squash slot with a valid input.
    issue(1'b1, 1, 3'd0, 32'h600, 32'h10, 32'd7, 32'd7, 1'b1, 1'b0);
    filler(1'b1);
    issue(1'b1, 0, 3'd0, 32'h700, 32'h0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(1'b1);
    filler(1'b1);
    idle(1'b1);

    // Reserved funct3, then reset in mid-stream.
    issue(1'b1, 1, 3'd2, 32'h800, 32'h4, 32'd9, 32'd9, 1'b1, 1'b0);
    filler(1'b0);
    reset_and_check();

    for (int i = 0; i < 3000; i++) begin
      a    = $urandom;
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = 1;
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = $urandom_range(0, 8) - 4;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 8) - 4;
      issue($urandom_range(0, 3) != 0, kind, 3'($urandom_range(0, 7)),
            $urandom, $urandom, a, b,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    for (int i = 0; i < 6; i++) idle(1'b1);
    @(negedge i_clk);
    #1;
    check("scoreboard drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
